// File: rtl/hdmi_pkg.sv
// Shared TMDS constants: symbol width, DVI control symbols, clock pattern.
// Also a small popcount helper used by the channel encoder.
package hdmi_pkg;

   localparam int SYM_W = 10;

   localparam logic [SYM_W-1:0] CTRL_00 = 10'b1101010100;
   localparam logic [SYM_W-1:0] CTRL_01 = 10'b0010101011;
   localparam logic [SYM_W-1:0] CTRL_10 = 10'b0101010100;
   localparam logic [SYM_W-1:0] CTRL_11 = 10'b1010101011;

   localparam logic [SYM_W-1:0] CLK_PATTERN_DEF = 10'b1111100000;

   function automatic logic [3:0] popcnt8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++)
         n = n + {3'b000, v[i]};
      return n;
   endfunction

endpackage

// File: rtl/hdmi_tmds_encoder_channel.sv
// One TMDS channel: transition-minimising stage A, DC-balancing stage B.
// Ports: clk, rst_n, de, c[1:0] control bits, d[7:0] component, q[9:0] symbol.
module tmds_channel_encoder
   import hdmi_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             de,
   input  logic [1:0]       c,
   input  logic [7:0]       d,
   output logic [SYM_W-1:0] q
);

   logic [8:0]        qm;
   logic [3:0]        n1d;
   logic [3:0]        n1q;
   logic              xn;
   logic signed [4:0] cnt;
   logic signed [4:0] cnt_nx;
   logic signed [4:0] diff;
   logic [SYM_W-1:0]  q_nx;

   always_comb begin
      logic [8:0] t;
      t   = '0;
      n1d = popcnt8(d);
      xn  = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
      t[0] = d[0];
      for (int i = 1; i < 8; i++)
         t[i] = xn ? ~(t[i-1] ^ d[i]) : (t[i-1] ^ d[i]);
      t[8] = ~xn;
      qm   = t;
   end

   // diff = n1q - n0q = 2*n1q - 8, wraps correctly in 5-bit signed
   always_comb begin
      n1q    = popcnt8(qm[7:0]);
      diff   = $signed({n1q, 1'b0}) - 5'sd8;
      q_nx   = CTRL_00;
      cnt_nx = cnt;
      if (!de) begin
         unique case (c)
            2'b00: q_nx = CTRL_00;
            2'b01: q_nx = CTRL_01;
            2'b10: q_nx = CTRL_10;
            2'b11: q_nx = CTRL_11;
         endcase
         cnt_nx = '0;
      end else if ((cnt == 5'sd0) || (diff == 5'sd0)) begin
         q_nx   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
         cnt_nx = qm[8] ? (cnt + diff) : (cnt - diff);
      end else if (((cnt > 5'sd0) && (diff > 5'sd0)) ||
                   ((cnt < 5'sd0) && (diff < 5'sd0))) begin
         q_nx   = {1'b1, qm[8], ~qm[7:0]};
         cnt_nx = cnt - diff + $signed({3'b000, qm[8], 1'b0});
      end else begin
         q_nx   = {1'b0, qm[8], qm[7:0]};
         cnt_nx = cnt + diff - $signed({3'b000, ~qm[8], 1'b0});
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q   <= CTRL_00;
         cnt <= '0;
      end else begin
         q   <= q_nx;
         cnt <= cnt_nx;
      end
   end

endmodule

// File: rtl/hdmi_tmds_encoder.sv
// DVI TMDS encoder: three channel encoders, optional input register, DE align.
// Ports: CLK_PX, RST_n, DE/HSYNC/VSYNC/HDMI_PX in; TMDS_CH0..2, TMDS_CLK_WORD, DE_OUT.
module hdmi_tmds_encoder
   import hdmi_pkg::*;
#(
   parameter int               INPUT_REG   = 1,
   parameter logic [SYM_W-1:0] CLK_PATTERN = CLK_PATTERN_DEF
)(
   input  logic             CLK_PX,
   input  logic             RST_n,
   input  logic             DE,
   input  logic             HSYNC,
   input  logic             VSYNC,
   input  logic [23:0]      HDMI_PX,
   output logic [SYM_W-1:0] TMDS_CH0,
   output logic [SYM_W-1:0] TMDS_CH1,
   output logic [SYM_W-1:0] TMDS_CH2,
   output logic [SYM_W-1:0] TMDS_CLK_WORD,
   output logic             DE_OUT
);

   logic        de_s;
   logic        hs_s;
   logic        vs_s;
   logic [23:0] px_s;

   generate
      if (INPUT_REG != 0) begin : g_inreg
         always_ff @(posedge CLK_PX or negedge RST_n) begin
            if (!RST_n) begin
               de_s <= 1'b0;
               hs_s <= 1'b0;
               vs_s <= 1'b0;
               px_s <= '0;
            end else begin
               de_s <= DE;
               hs_s <= HSYNC;
               vs_s <= VSYNC;
               px_s <= HDMI_PX;
            end
         end
      end else begin : g_direct
         assign de_s = DE;
         assign hs_s = HSYNC;
         assign vs_s = VSYNC;
         assign px_s = HDMI_PX;
      end
   endgenerate

   // DE_OUT goes through the same single register as the symbols
   always_ff @(posedge CLK_PX or negedge RST_n) begin
      if (!RST_n)
         DE_OUT <= 1'b0;
      else
         DE_OUT <= de_s;
   end

   tmds_channel_encoder u_ch0 (
      .clk   (CLK_PX),
      .rst_n (RST_n),
      .de    (de_s),
      .c     ({vs_s, hs_s}),
      .d     (px_s[7:0]),
      .q     (TMDS_CH0)
   );

   tmds_channel_encoder u_ch1 (
      .clk   (CLK_PX),
      .rst_n (RST_n),
      .de    (de_s),
      .c     (2'b00),
      .d     (px_s[15:8]),
      .q     (TMDS_CH1)
   );

   tmds_channel_encoder u_ch2 (
      .clk   (CLK_PX),
      .rst_n (RST_n),
      .de    (de_s),
      .c     (2'b00),
      .d     (px_s[23:16]),
      .q     (TMDS_CH2)
   );

   assign TMDS_CLK_WORD = CLK_PATTERN;

endmodule

// File: tb/tb_hdmi_tmds_encoder.sv
// Scoreboard bench for hdmi_tmds_encoder: reference encoder + decoder model.
// Directed control/black/white/reset cases, then a long random run.
`timescale 1ns/1ps
module tb_hdmi_tmds_encoder;

   localparam int INPUT_REG = 1;
   localparam int LAT       = (INPUT_REG != 0) ? 2 : 1;

   logic        CLK_PX = 1'b0;
   logic        RST_n  = 1'b0;
   logic        DE     = 1'b0;
   logic        HSYNC  = 1'b0;
   logic        VSYNC  = 1'b0;
   logic [23:0] HDMI_PX = '0;
   logic [9:0]  TMDS_CH0;
   logic [9:0]  TMDS_CH1;
   logic [9:0]  TMDS_CH2;
   logic [9:0]  TMDS_CLK_WORD;
   logic        DE_OUT;

   hdmi_tmds_encoder #(.INPUT_REG(INPUT_REG)) dut (
      .CLK_PX        (CLK_PX),
      .RST_n         (RST_n),
      .DE            (DE),
      .HSYNC         (HSYNC),
      .VSYNC         (VSYNC),
      .HDMI_PX       (HDMI_PX),
      .TMDS_CH0      (TMDS_CH0),
      .TMDS_CH1      (TMDS_CH1),
      .TMDS_CH2      (TMDS_CH2),
      .TMDS_CLK_WORD (TMDS_CLK_WORD),
      .DE_OUT        (DE_OUT)
   );

   always #5 CLK_PX = ~CLK_PX;

   typedef struct {
      logic        de;
      logic        hs;
      logic        vs;
      logic [23:0] px;
      logic [9:0]  e0;
      logic [9:0]  e1;
      logic [9:0]  e2;
   } item_t;

   item_t sbq[$];
   int    checks  = 0;
   int    errors  = 0;
   int    drv_cnt = 0;
   int    mon_cnt = 0;
   bit    mon_en  = 1'b0;
   int    mcnt[3];
   int    disp[3];
   bit    prev_de = 1'b0;

   // Reference encoder. The k-th bit of an XOR chain is the parity of
   // d[k:0]; an XNOR chain adds one inversion per step, i.e. k mod 2.
   function automatic logic [9:0] ref_enc(input int ch, input logic [7:0] d,
                                          input bit de, input logic [1:0] c);
      logic [7:0] qm;
      logic [7:0] m;
      bit   use_xn, q8, inv;
      int   n1d, n1, n0;
      if (!de) begin
         mcnt[ch] = 0;
         case (c)
            2'b00: return 10'b1101010100;
            2'b01: return 10'b0010101011;
            2'b10: return 10'b0101010100;
            default: return 10'b1010101011;
         endcase
      end
      n1d    = $countones(d);
      use_xn = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
      q8     = !use_xn;
      for (int k = 0; k < 8; k++) begin
         m     = 8'((16'd2 << k) - 16'd1);
         qm[k] = (^(d & m)) ^ (use_xn && (k % 2 == 1));
      end
      n1 = $countones(qm);
      n0 = 8 - n1;
      if (mcnt[ch] == 0 || n1 == n0) begin
         inv = !q8;
         mcnt[ch] += q8 ? (n1 - n0) : (n0 - n1);
      end else if ((mcnt[ch] > 0 && n1 > n0) || (mcnt[ch] < 0 && n0 > n1)) begin
         inv = 1'b1;
         mcnt[ch] += 2 * int'(q8) + (n0 - n1);
      end else begin
         inv = 1'b0;
         mcnt[ch] += (n1 - n0) - 2 * int'(!q8);
      end
      return {inv, q8, inv ? ~qm : qm};
   endfunction

   function automatic logic [7:0] dec_data(input logic [9:0] s);
      logic [7:0] d;
      logic [7:0] o;
      d    = s[9] ? ~s[7:0] : s[7:0];
      o[0] = d[0];
      for (int i = 1; i < 8; i++)
         o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      return o;
   endfunction

   function automatic int dec_ctrl(input logic [9:0] s);
      case (s)
         10'b1101010100: return 0;
         10'b0010101011: return 1;
         10'b0101010100: return 2;
         10'b1010101011: return 3;
         default:        return -1;
      endcase
   endfunction

   task automatic drive(input bit de, input bit hs, input bit vs,
                        input logic [23:0] px, input bit fix,
                        input logic [9:0] f0, input logic [9:0] f1,
                        input logic [9:0] f2);
      item_t it;
      @(posedge CLK_PX);
      #1;
      DE      = de;
      HSYNC   = hs;
      VSYNC   = vs;
      HDMI_PX = px;
      it.de = de;
      it.hs = hs;
      it.vs = vs;
      it.px = px;
      it.e0 = ref_enc(0, px[7:0],   de, {vs, hs});
      it.e1 = ref_enc(1, px[15:8],  de, 2'b00);
      it.e2 = ref_enc(2, px[23:16], de, 2'b00);
      if (fix) begin
         it.e0 = f0;
         it.e1 = f1;
         it.e2 = f2;
      end
      sbq.push_back(it);
      drv_cnt++;
   endtask

   task automatic drv(input bit de, input bit hs, input bit vs,
                      input logic [23:0] px);
      drive(de, hs, vs, px, 1'b0, '0, '0, '0);
   endtask

   task automatic drv_fix(input bit de, input bit hs, input bit vs,
                          input logic [23:0] px, input logic [9:0] f0,
                          input logic [9:0] f12);
      drive(de, hs, vs, px, 1'b1, f0, f12, f12);
   endtask

   task automatic chk_rst(input string name);
      checks++;
      if (TMDS_CH0 !== 10'b1101010100 || TMDS_CH1 !== 10'b1101010100 ||
          TMDS_CH2 !== 10'b1101010100 || DE_OUT !== 1'b0) begin
         errors++;
         $display("FAIL %s: got ch0=%b ch1=%b ch2=%b de=%b, want 1101010100 x3 de=0",
                  name, TMDS_CH0, TMDS_CH1, TMDS_CH2, DE_OUT);
      end
   endtask

   always @(negedge CLK_PX) begin
      item_t it;
      logic [23:0] dpx;
      int   cc;
      if (mon_en && sbq.size() > 0 && drv_cnt > mon_cnt + LAT) begin
         it = sbq.pop_front();
         mon_cnt++;
         checks++;
         if ({TMDS_CH2, TMDS_CH1, TMDS_CH0, DE_OUT} !==
             {it.e2, it.e1, it.e0, it.de}) begin
            errors++;
            $display("FAIL sym#%0d: got %b %b %b de=%b, want %b %b %b de=%b",
                     mon_cnt - 1, TMDS_CH2, TMDS_CH1, TMDS_CH0, DE_OUT,
                     it.e2, it.e1, it.e0, it.de);
         end
         checks++;
         if (it.de) begin
            dpx = {dec_data(TMDS_CH2), dec_data(TMDS_CH1), dec_data(TMDS_CH0)};
            if (dpx !== it.px) begin
               errors++;
               $display("FAIL decode#%0d: got px=%h, want %h",
                        mon_cnt - 1, dpx, it.px);
            end
            disp[0] += 2 * $countones(TMDS_CH0) - 10;
            disp[1] += 2 * $countones(TMDS_CH1) - 10;
            disp[2] += 2 * $countones(TMDS_CH2) - 10;
         end else begin
            cc = dec_ctrl(TMDS_CH0);
            if (cc != int'({it.vs, it.hs}) || dec_ctrl(TMDS_CH1) != 0 ||
                dec_ctrl(TMDS_CH2) != 0) begin
               errors++;
               $display("FAIL ctrl#%0d: got ch0 code %0d, want %0d",
                        mon_cnt - 1, cc, int'({it.vs, it.hs}));
            end
            if (prev_de) begin
               checks++;
               if (disp[0] > 10 || disp[0] < -10 || disp[1] > 10 ||
                   disp[1] < -10 || disp[2] > 10 || disp[2] < -10) begin
                  errors++;
                  $display("FAIL disparity: got %0d %0d %0d, want within +/-10",
                           disp[0], disp[1], disp[2]);
               end
            end
            disp[0] = 0;
            disp[1] = 0;
            disp[2] = 0;
         end
         prev_de = it.de;
      end
   end

   initial begin
      int pix;
      int len;
      bit hs;
      bit vs;
      mcnt[0] = 0; mcnt[1] = 0; mcnt[2] = 0;
      disp[0] = 0; disp[1] = 0; disp[2] = 0;

      // reset held, inputs busy
      DE = 1'b1;
      HDMI_PX = 24'hFFFFFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK_PX);
         chk_rst("reset_hold");
      end
      checks++;
      if (TMDS_CLK_WORD !== 10'b1111100000) begin
         errors++;
         $display("FAIL clk_word: got %b, want 1111100000", TMDS_CLK_WORD);
      end
      DE = 1'b0;
      HDMI_PX = '0;
      @(posedge CLK_PX);
      #1;
      RST_n  = 1'b1;
      mon_en = 1'b1;

      // control symbols
      repeat (2) drv_fix(0, 0, 0, 24'h0, 10'b1101010100, 10'b1101010100);
      repeat (3) drv_fix(0, 1, 0, 24'h0, 10'b0010101011, 10'b1101010100);
      repeat (2) drv_fix(0, 1, 1, 24'h0, 10'b1010101011, 10'b1101010100);
      drv_fix(0, 0, 1, 24'h0, 10'b0101010100, 10'b1101010100);
      drv_fix(0, 0, 0, 24'h0, 10'b1101010100, 10'b1101010100);

      // black line
      drv_fix(1, 0, 0, 24'h000000, 10'b0100000000, 10'b0100000000);
      drv_fix(1, 0, 0, 24'h000000, 10'b1111111111, 10'b1111111111);
      drv_fix(1, 0, 0, 24'h000000, 10'b0100000000, 10'b0100000000);
      drv_fix(0, 0, 0, 24'h0,      10'b1101010100, 10'b1101010100);
      // white line
      drv_fix(1, 0, 0, 24'hFFFFFF, 10'b1000000000, 10'b1000000000);
      drv_fix(1, 0, 0, 24'hFFFFFF, 10'b0011111111, 10'b0011111111);
      // single blank clears disparity
      drv_fix(0, 0, 0, 24'h0,      10'b1101010100, 10'b1101010100);
      drv_fix(1, 0, 0, 24'h000000, 10'b0100000000, 10'b0100000000);
      drv(1, 0, 0, 24'h123456);
      drv(1, 0, 0, 24'h000000);
      repeat (LAT + 1) drv(1, 0, 0, 24'h000000);

      // asynchronous reset mid-line
      @(posedge CLK_PX);
      #2;
      mon_en = 1'b0;
      RST_n  = 1'b0;
      #1;
      chk_rst("reset_midline");
      sbq.delete();
      drv_cnt = 0;
      mon_cnt = 0;
      mcnt[0] = 0; mcnt[1] = 0; mcnt[2] = 0;
      disp[0] = 0; disp[1] = 0; disp[2] = 0;
      prev_de = 1'b0;
      DE = 1'b0;
      HDMI_PX = '0;
      @(negedge CLK_PX);
      chk_rst("reset_midline_hold");
      @(posedge CLK_PX);
      #1;
      RST_n  = 1'b1;
      mon_en = 1'b1;

      // restart from cnt=0 with black pixels
      drv_fix(1, 0, 0, 24'h000000, 10'b0100000000, 10'b0100000000);
      drv_fix(1, 0, 0, 24'h000000, 10'b1111111111, 10'b1111111111);

      // random lines with random blanking
      pix = 0;
      while (pix < 10000) begin
         len = $urandom_range(1, 64);
         for (int i = 0; i < len; i++) begin
            drv(1, 0, 0, 24'($urandom));
            pix++;
         end
         len = $urandom_range(1, 8);
         hs  = 1'($urandom);
         vs  = 1'($urandom);
         for (int i = 0; i < len; i++)
            drv(0, hs, vs, 24'($urandom));
      end
      repeat (LAT + 1) drv(0, 0, 0, 24'h0);

      @(negedge CLK_PX);
      #1;
      checks++;
      if (mon_cnt != drv_cnt - LAT) begin
         errors++;
         $display("FAIL drain: got %0d symbols checked, want %0d",
                  mon_cnt, drv_cnt - LAT);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
